// File: rtl/ex_mem_stage_buf_if.sv
// ex_mem_stage_buf_if: EX-side input and MEM-side output bundle of the EX/MEM stage buffer
interface ex_mem_stage_buf_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
);
   logic              in_valid;
   logic              in_ready;
   logic              RegWrite_in;
   logic              MemtoReg_in;
   logic              MemRead_in;
   logic              MemWrite_in;
   logic [DATA_W-1:0] ALU_Result_in;
   logic [DATA_W-1:0] RT_data_in;
   logic [REG_W-1:0]  Dest_reg_in;
   logic              out_valid;
   logic              out_ready;
   logic              RegWrite_out;
   logic              MemtoReg_out;
   logic              MemRead_out;
   logic              MemWrite_out;
   logic [DATA_W-1:0] ALU_Result_out;
   logic [DATA_W-1:0] RT_data_out;
   logic [REG_W-1:0]  Dest_reg_out;
   logic              fwd_en;
   logic [REG_W-1:0]  fwd_reg;
   logic [DATA_W-1:0] fwd_data;
   logic              load_hazard;

   modport master (
      output in_valid, RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
             ALU_Result_in, RT_data_in, Dest_reg_in, out_ready,
      input  in_ready, out_valid, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
             ALU_Result_out, RT_data_out, Dest_reg_out, fwd_en, fwd_reg, fwd_data, load_hazard
   );

   modport slave (
      input  in_valid, RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
             ALU_Result_in, RT_data_in, Dest_reg_in, out_ready,
      output in_ready, out_valid, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
             ALU_Result_out, RT_data_out, Dest_reg_out, fwd_en, fwd_reg, fwd_data, load_hazard
   );
endinterface

// File: rtl/ex_mem_stage_buf.sv
// ex_mem_stage_buf: EX/MEM pipeline register with 2-entry skid buffer, flush, forwarding and stall counter
module ex_mem_stage_buf #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset_in,
   input  logic             flush_in,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] stall_cnt,
   ex_mem_stage_buf_if.slave bus
);
   localparam int E_W = 4 + 2 * DATA_W + REG_W;

   logic [E_W-1:0]    w_in_entry;
   logic [E_W-1:0]    r_main;
   logic [E_W-1:0]    r_skid;
   logic              r_main_valid;
   logic              r_skid_valid;
   logic              w_in_fire;
   logic              w_out_fire;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic              w_rw;
   logic              w_m2r;
   logic              w_mr;
   logic              w_mw;
   logic [DATA_W-1:0] w_alu;
   logic [DATA_W-1:0] w_rt;
   logic [REG_W-1:0]  w_dst;

   // writes to $zero are neutralised at capture so nothing downstream sees them
   assign w_in_entry = {bus.RegWrite_in & (bus.Dest_reg_in != '0), bus.MemtoReg_in,
                        bus.MemRead_in, bus.MemWrite_in, bus.ALU_Result_in,
                        bus.RT_data_in, bus.Dest_reg_in};
   assign w_in_fire  = bus.in_valid & ~r_skid_valid;
   assign w_out_fire = r_main_valid & bus.out_ready;

   // in_ready comes straight from a flop, so MEM back-pressure never reaches EX combinationally
   assign bus.in_ready  = ~r_skid_valid;
   assign bus.out_valid = r_main_valid;

   assign {w_rw, w_m2r, w_mr, w_mw, w_alu, w_rt, w_dst} = r_main;
   assign bus.RegWrite_out   = r_main_valid & w_rw;
   assign bus.MemtoReg_out   = r_main_valid & w_m2r;
   assign bus.MemRead_out    = r_main_valid & w_mr;
   assign bus.MemWrite_out   = r_main_valid & w_mw;
   assign bus.ALU_Result_out = w_alu;
   assign bus.RT_data_out    = w_rt;
   assign bus.Dest_reg_out   = w_dst;
   assign bus.fwd_en         = r_main_valid & w_rw;
   assign bus.fwd_reg        = w_dst;
   assign bus.fwd_data       = w_alu;
   assign bus.load_hazard    = r_main_valid & w_mr & (w_dst != '0);
   assign stall_cnt          = r_stall_cnt;

   // head/skid occupancy: main fills first, skid only absorbs an entry while main is stalled
   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         r_main       <= '0;
         r_skid       <= '0;
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (flush_in) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (!r_main_valid) begin
         if (w_in_fire) begin
            r_main       <= w_in_entry;
            r_main_valid <= 1'b1;
         end
      end else if (!r_skid_valid) begin
         if (w_in_fire && w_out_fire) begin
            r_main <= w_in_entry;
         end else if (w_out_fire) begin
            r_main_valid <= 1'b0;
         end else if (w_in_fire) begin
            r_skid       <= w_in_entry;
            r_skid_valid <= 1'b1;
         end
      end else if (w_out_fire) begin
         r_main       <= r_skid;
         r_skid_valid <= 1'b0;
      end
   end

   // saturating count of cycles the head entry waits on MEM; clear wins over increment
   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         r_stall_cnt <= '0;
      end else if (cnt_clr) begin
         r_stall_cnt <= '0;
      end else if (r_main_valid && !bus.out_ready && r_stall_cnt != '1) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// tb_ex_mem_stage_buf: randomized and directed checks of ex_mem_stage_buf against a queue model
module tb_ex_mem_stage_buf;
   localparam int DW = 32;
   localparam int RW = 5;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct packed {
      logic          rw;
      logic          m2r;
      logic          mr;
      logic          mw;
      logic [DW-1:0] alu;
      logic [DW-1:0] rt;
      logic [RW-1:0] dst;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset_in = 1'b0;
   logic          flush_in = 1'b0;
   logic          cnt_clr = 1'b0;
   logic [CW-1:0] stall_cnt;

   ex_mem_stage_buf_if #(.DATA_W(DW), .REG_W(RW)) bus ();

   ex_mem_stage_buf #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
      .clk(clk), .reset_in(reset_in), .flush_in(flush_in), .cnt_clr(cnt_clr),
      .stall_cnt(stall_cnt), .bus(bus)
   );

   always #5 clk = ~clk;

   ent_t q[$];
   ent_t last;
   int   cnt;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic ent_t mk(input logic rw, input logic mr, input logic [DW-1:0] alu, input logic [RW-1:0] dst);
      ent_t e;
      e = '0;
      e.rw = rw;
      e.mr = mr;
      e.alu = alu;
      e.rt = ~alu;
      e.dst = dst;
      return e;
   endfunction

   function automatic ent_t rnd_ent();
      ent_t e;
      e.rw  = 1'($urandom);
      e.m2r = 1'($urandom);
      e.mr  = 1'($urandom);
      e.mw  = 1'($urandom);
      e.alu = DW'($urandom);
      e.rt  = DW'($urandom);
      e.dst = ($urandom_range(0, 3) == 0) ? '0 : RW'($urandom_range(0, 31));
      return e;
   endfunction

   task automatic drive(input logic v, input ent_t e, input logic ordy, input logic fl, input logic clr);
      bus.in_valid      = v;
      bus.RegWrite_in   = e.rw;
      bus.MemtoReg_in   = e.m2r;
      bus.MemRead_in    = e.mr;
      bus.MemWrite_in   = e.mw;
      bus.ALU_Result_in = e.alu;
      bus.RT_data_in    = e.rt;
      bus.Dest_reg_in   = e.dst;
      bus.out_ready     = ordy;
      flush_in          = fl;
      cnt_clr           = clr;
   endtask

   task automatic check_all();
      logic v;
      v = q.size() > 0;
      chk("in_ready", bus.in_ready, q.size() < 2);
      chk("out_valid", bus.out_valid, v);
      chk("RegWrite_out", bus.RegWrite_out, v & last.rw);
      chk("MemtoReg_out", bus.MemtoReg_out, v & last.m2r);
      chk("MemRead_out", bus.MemRead_out, v & last.mr);
      chk("MemWrite_out", bus.MemWrite_out, v & last.mw);
      chk("ALU_Result_out", bus.ALU_Result_out, last.alu);
      chk("RT_data_out", bus.RT_data_out, last.rt);
      chk("Dest_reg_out", bus.Dest_reg_out, last.dst);
      chk("fwd_en", bus.fwd_en, v & last.rw);
      chk("fwd_reg", bus.fwd_reg, last.dst);
      chk("fwd_data", bus.fwd_data, last.alu);
      chk("load_hazard", bus.load_hazard, v & last.mr & (last.dst != 0));
      chk("stall_cnt", stall_cnt, cnt);
   endtask

   task automatic cycle();
      logic inf, outf;
      ent_t e;
      inf  = bus.in_valid && q.size() < 2;
      outf = q.size() > 0 && bus.out_ready;
      if (cnt_clr) cnt = 0;
      else if (q.size() > 0 && !bus.out_ready && cnt < CMAX) cnt++;
      if (flush_in) begin
         q.delete();
      end else begin
         if (outf) void'(q.pop_front());
         if (inf) begin
            e = {bus.RegWrite_in, bus.MemtoReg_in, bus.MemRead_in, bus.MemWrite_in,
                 bus.ALU_Result_in, bus.RT_data_in, bus.Dest_reg_in};
            if (e.dst == 0) e.rw = 1'b0;
            q.push_back(e);
         end
      end
      if (q.size() > 0) last = q[0];
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      #2 reset_in = 1'b1;
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_RegWrite", bus.RegWrite_out, 0);
      chk("rst_MemRead", bus.MemRead_out, 0);
      chk("rst_ALU", bus.ALU_Result_out, 0);
      chk("rst_RT", bus.RT_data_out, 0);
      chk("rst_dst", bus.Dest_reg_out, 0);
      chk("rst_stall", stall_cnt, 0);
      q.delete();
      last = '0;
      cnt = 0;
      @(negedge clk);
      reset_in = 1'b0;
      #1;
      chk("rst_in_ready", bus.in_ready, 1);
      check_all();
      @(negedge clk);
   endtask

   initial begin
      ent_t z;
      z = '0;
      drive(0, z, 0, 0, 0);
      @(negedge clk);
      do_reset();

      for (int i = 0; i < 4; i++) begin
         drive(1, mk(1, 0, DW'((i + 1) * 16), 8), 1, 0, 0);
         cycle();
         chk("stream_alu", bus.ALU_Result_out, (i + 1) * 16);
         chk("stream_rdy", bus.in_ready, 1);
      end
      drive(0, z, 1, 0, 0);
      cycle();

      drive(1, mk(1, 0, 'hA, 3), 0, 0, 0);
      cycle();
      drive(1, mk(1, 0, 'hB, 4), 0, 0, 0);
      cycle();
      chk("bp_rdy", bus.in_ready, 0);
      chk("bp_head", bus.ALU_Result_out, 'hA);
      drive(0, z, 0, 0, 0);
      cycle();
      chk("bp_stall", stall_cnt, 2);
      drive(0, z, 1, 0, 0);
      cycle();
      chk("bp_second", bus.ALU_Result_out, 'hB);
      chk("bp_rdy_back", bus.in_ready, 1);
      cycle();
      chk("bp_empty", bus.out_valid, 0);

      drive(1, mk(1, 0, 'hA, 3), 0, 0, 0);
      cycle();
      drive(1, mk(1, 0, 'hB, 4), 0, 0, 0);
      cycle();
      drive(1, mk(1, 0, 'hC, 5), 0, 1, 0);
      cycle();
      chk("flush_valid", bus.out_valid, 0);
      chk("flush_rw", bus.RegWrite_out, 0);
      drive(0, z, 1, 0, 0);
      cycle();
      chk("flush_gone", bus.out_valid, 0);

      drive(1, mk(1, 0, 'h55, 0), 1, 0, 0);
      cycle();
      chk("zero_fwd_en", bus.fwd_en, 0);
      drive(1, mk(1, 0, 'h66, 8), 1, 0, 0);
      cycle();
      chk("fwd_en8", bus.fwd_en, 1);
      chk("fwd_reg8", bus.fwd_reg, 8);
      drive(1, mk(0, 1, 'h77, 9), 1, 0, 0);
      cycle();
      chk("load_hz9", bus.load_hazard, 1);

      drive(1, mk(0, 0, 'h1, 1), 0, 0, 0);
      cycle();
      drive(0, z, 0, 0, 1);
      cycle();
      drive(0, z, 0, 0, 0);
      for (int i = 0; i < 20; i++) cycle();
      chk("sat", stall_cnt, CMAX);
      drive(0, z, 0, 0, 1);
      cycle();
      chk("sat_clr", stall_cnt, 0);

      drive(1, mk(1, 1, 'hD, 6), 0, 0, 0);
      cycle();
      drive(1, mk(1, 1, 'hE, 7), 0, 0, 0);
      cycle();
      chk("pre_rst_full", bus.in_ready, 0);
      do_reset();

      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 3) != 0, rnd_ent(), $urandom_range(0, 2) != 0,
               $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
         cycle();
         if (i == 1500) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
